// File: rtl/tmon_sched_pkg.sv
// Shared definitions for the tmon request scheduler: master opcodes, scheduler
// states and default sizing constants.
package tmon_sched_pkg;

   localparam int OP_W            = 2;
   localparam int DEF_NREQ        = 3;
   localparam int DEF_POLL_PERIOD = 8;
   localparam int DEF_TIMEOUT     = 16;

   typedef enum logic [OP_W-1:0] {
      NOOP     = 2'd0,
      GET_TEMP = 2'd1,
      SET_HI   = 2'd2,
      SET_LO   = 2'd3
   } tmon_op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } sched_st_e;

endpackage

// File: rtl/tmon_sched_arb.sv
// Round-robin arbiter: picks the first asserted request searching upward from
// ptr_i and wrapping at N.
module tmon_rr_arb #(
   parameter int N = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [IW-1:0] gnt_o,
   output logic          any_o
);

   logic [IW-1:0] idx;

   // Walk the search order backwards so the candidate closest to ptr_i is written last.
   always_comb begin
      gnt_o = '0;
      any_o = 1'b0;
      idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = IW'((int'(ptr_i) + k) % N);
         if (req_i[idx]) begin
            gnt_o = idx;
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tmon_sched.sv
// Scheduler sharing the tmon_master request port between NREQ hosts and an
// internal temperature poll, one outstanding transaction with a Done timeout.
module tmon_sched
   import tmon_sched_pkg::*;
#(
   parameter int NREQ        = DEF_NREQ,
   parameter int POLL_PERIOD = DEF_POLL_PERIOD,
   parameter int TIMEOUT     = DEF_TIMEOUT
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NREQ-1:0]      req_valid_i,
   input  logic [NREQ*OP_W-1:0] req_op_i,
   input  logic [NREQ*8-1:0]    req_data_i,
   output logic [NREQ-1:0]      req_ready_o,
   output logic [NREQ-1:0]      rsp_valid_o,
   output logic [7:0]           rsp_data_o,
   output logic                 rsp_err_o,
   output logic [OP_W-1:0]      request_o,
   output logic [7:0]           reqData_o,
   input  logic                 Done_i,
   input  logic [7:0]           mstData_i,
   output logic [7:0]           last_temp_o,
   output logic                 temp_valid_o
);

   localparam int NS = NREQ + 1;
   localparam int IW = $clog2(NS);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int PW = (POLL_PERIOD > 0) ? $clog2(POLL_PERIOD + 1) : 1;
   localparam logic [PW-1:0] POLL_LAST = PW'((POLL_PERIOD > 0) ? POLL_PERIOD - 1 : 0);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
   localparam logic [IW-1:0] POLL_SLOT = IW'(NREQ);

   sched_st_e     state_q;
   logic [IW-1:0] winner_q, rrPtr_q;
   tmon_op_e      op_q, request_q;
   logic [7:0]    data_q, capData_q, reqData_q, rspData_q, lastTemp_q;
   logic          capErr_q, rspErr_q, tempValid_q, pollPend_q;
   logic [TW-1:0] tmoCnt_q;
   logic [PW-1:0] pollCnt_q;
   logic [NREQ-1:0] reqReady_q, rspValid_q;

   logic [NS-1:0] cand_d;
   logic [IW-1:0] gnt_d, rrNext_d;
   logic          any_d, pollTake_d;
   tmon_op_e      opSel_d;
   logic [7:0]    dataSel_d;

   // NOOP requests never compete; the poll source sits in the extra top slot.
   always_comb begin
      cand_d = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand_d[i] = req_valid_i[i] && (req_op_i[i*OP_W +: OP_W] != NOOP);
      end
      cand_d[NREQ] = pollPend_q;
   end

   tmon_rr_arb #(.N(NS)) uArb (
      .req_i (cand_d),
      .ptr_i (rrPtr_q),
      .gnt_o (gnt_d),
      .any_o (any_d)
   );

   always_comb begin
      opSel_d   = GET_TEMP;
      dataSel_d = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_d == IW'(i)) begin
            opSel_d   = tmon_op_e'(req_op_i[i*OP_W +: OP_W]);
            dataSel_d = req_data_i[i*8 +: 8];
         end
      end
      rrNext_d   = (gnt_d == POLL_SLOT) ? '0 : gnt_d + IW'(1);
      pollTake_d = (state_q == S_ISSUE) && (winner_q == POLL_SLOT);
   end

   // A wrap coinciding with the poll being taken keeps the request pending.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pollCnt_q  <= '0;
         pollPend_q <= 1'b0;
      end else if (POLL_PERIOD > 0) begin
         if (pollCnt_q == POLL_LAST) begin
            pollCnt_q  <= '0;
            pollPend_q <= 1'b1;
         end else begin
            pollCnt_q <= pollCnt_q + PW'(1);
            if (pollTake_d) begin
               pollPend_q <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         winner_q    <= '0;
         rrPtr_q     <= '0;
         op_q        <= NOOP;
         data_q      <= '0;
         tmoCnt_q    <= '0;
         capData_q   <= '0;
         capErr_q    <= 1'b0;
         reqReady_q  <= '0;
         rspValid_q  <= '0;
         rspData_q   <= '0;
         rspErr_q    <= 1'b0;
         request_q   <= NOOP;
         reqData_q   <= '0;
         lastTemp_q  <= '0;
         tempValid_q <= 1'b0;
      end else begin
         reqReady_q <= '0;
         rspValid_q <= '0;
         request_q  <= NOOP;
         reqData_q  <= '0;
         case (state_q)
            S_IDLE: begin
               if (any_d) begin
                  winner_q <= gnt_d;
                  op_q     <= opSel_d;
                  data_q   <= dataSel_d;
                  rrPtr_q  <= rrNext_d;
                  state_q  <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               request_q <= op_q;
               reqData_q <= data_q;
               for (int i = 0; i < NREQ; i++) begin
                  if (winner_q == IW'(i)) begin
                     reqReady_q[i] <= 1'b1;
                  end
               end
               tmoCnt_q <= '0;
               state_q  <= S_WAIT;
            end
            // Done is checked first so it wins over a timeout in the same cycle.
            S_WAIT: begin
               if (Done_i) begin
                  capData_q <= mstData_i;
                  capErr_q  <= 1'b0;
                  state_q   <= S_RESP;
               end else if (tmoCnt_q == TO_LAST) begin
                  capData_q <= '0;
                  capErr_q  <= 1'b1;
                  state_q   <= S_RESP;
               end else begin
                  tmoCnt_q <= tmoCnt_q + TW'(1);
               end
            end
            S_RESP: begin
               if (winner_q == POLL_SLOT) begin
                  if (!capErr_q) begin
                     lastTemp_q  <= capData_q;
                     tempValid_q <= 1'b1;
                  end
               end else begin
                  for (int i = 0; i < NREQ; i++) begin
                     if (winner_q == IW'(i)) begin
                        rspValid_q[i] <= 1'b1;
                     end
                  end
                  rspData_q <= capData_q;
                  rspErr_q  <= capErr_q;
               end
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready_o  = reqReady_q;
   assign rsp_valid_o  = rspValid_q;
   assign rsp_data_o   = rspData_q;
   assign rsp_err_o    = rspErr_q;
   assign request_o    = request_q;
   assign reqData_o    = reqData_q;
   assign last_temp_o  = lastTemp_q;
   assign temp_valid_o = tempValid_q;

endmodule
